mmio_router: RTL and testbench

Downstream neighbour of the core bus arbiter. Takes the single granted data-port request (physical address, read/write strobes, write data) and dispatches it to one of three memory-mapped peripheral targets: CLINT, PLIC or UART. It drives the per-target busy vector that the arbiter folds into its system-busy condition, and returns read data once busy falls. Unmapped addresses and unresponsive targets complete with an error pulse, so the arbiter never hangs.

---
 rtl/mmio_router_pkg.sv | 32 +++
 rtl/mmio_router_if.sv | 32 +++
 rtl/mmio_router_decode.sv | 29 ++
 rtl/mmio_router.sv | 169 ++++++++++++++++
 tb/tb_mmio_router.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_router_pkg.sv
// Shared constants for the MMIO router: target windows, target indices,
// busy-vector layout and FSM encoding.
package mmio_pkg;

    localparam int NUM_TGT   = 3;
    localparam int TGT_CLINT = 0;
    localparam int TGT_PLIC  = 1;
    localparam int TGT_UART  = 2;
    localparam int BUSY_ERR  = 3;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_SIZE = 32'h0001_0000;
    localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
    localparam logic [31:0] PLIC_SIZE  = 32'h0400_0000;
    localparam logic [31:0] UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] UART_SIZE  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Unsigned wrap makes addresses below base land far above size.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/mmio_router_if.sv
// Arbiter-side request/response and target-side access signals of the router.
// slave is the router view; master is the surrounding arbiter and targets.
interface mmio_router_if;
    logic [31:0] req_paddr;
    logic        req_le;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  busy;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  tgt_sel;
    logic [31:0] tgt_addr;
    logic        tgt_re;
    logic        tgt_we;
    logic [31:0] tgt_wdata;
    logic [2:0]  tgt_ack;
    logic [31:0] tgt_rdata_clint;
    logic [31:0] tgt_rdata_plic;
    logic [31:0] tgt_rdata_uart;

    modport slave (
        input  req_paddr, req_le, req_we, req_wdata,
        input  tgt_ack, tgt_rdata_clint, tgt_rdata_plic, tgt_rdata_uart,
        output busy, rdata, err, tgt_sel, tgt_addr, tgt_re, tgt_we, tgt_wdata
    );

    modport master (
        output req_paddr, req_le, req_we, req_wdata,
        output tgt_ack, tgt_rdata_clint, tgt_rdata_plic, tgt_rdata_uart,
        input  busy, rdata, err, tgt_sel, tgt_addr, tgt_re, tgt_we, tgt_wdata
    );
endinterface

// File: rtl/mmio_router_decode.sv
// Combinational address decode: physical address to one-hot target,
// unmapped flag and offset within the selected window.
module mmio_decode
    import mmio_pkg::*;
(
    input  logic [31:0]        paddr,
    output logic [NUM_TGT-1:0] sel,
    output logic               unmapped,
    output logic [31:0]        offset
);

    always_comb begin
        sel    = '0;
        offset = '0;
        if (in_window(paddr, CLINT_BASE, CLINT_SIZE)) begin
            sel[TGT_CLINT] = 1'b1;
            offset         = paddr - CLINT_BASE;
        end else if (in_window(paddr, PLIC_BASE, PLIC_SIZE)) begin
            sel[TGT_PLIC] = 1'b1;
            offset        = paddr - PLIC_BASE;
        end else if (in_window(paddr, UART_BASE, UART_SIZE)) begin
            sel[TGT_UART] = 1'b1;
            offset        = paddr - UART_BASE;
        end
    end

    assign unmapped = (sel == '0);

endmodule

// File: rtl/mmio_router.sv
// Dispatches the granted data-port access to CLINT, PLIC or UART and reports
// per-target busy, read data and an error pulse for unmapped or stuck accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an armed request
// ST_ISSUE | one-cycle access strobe to the selected target
// ST_WAIT  | strobe done, waiting for ack or timeout
// ST_DONE  | one cycle closing the transaction, busy/tgt_sel drop after
module mmio_router
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          CLK,
    input logic          RST_X,
    mmio_router_if.slave bus
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);

    state_t               state, state_nxt;
    logic                 armed, armed_nxt;
    logic                 is_wr, is_wr_nxt;
    logic [3:0]           busy_q, busy_nxt;
    logic [31:0]          rdata_q, rdata_nxt;
    logic                 err_q, err_nxt;
    logic [NUM_TGT-1:0]   sel_q, sel_nxt;
    logic [31:0]          addr_q, addr_nxt;
    logic                 re_q, re_nxt;
    logic                 we_q, we_nxt;
    logic [31:0]          wdata_q, wdata_nxt;
    logic [7:0]           tmo_cnt, tmo_nxt;

    logic [NUM_TGT-1:0]   dec_sel;
    logic                 dec_unmapped;
    logic [31:0]          dec_offset;
    logic                 req_any;
    logic                 ack_hit;
    logic [31:0]          ack_rdata;

    mmio_decode u_decode (
        .paddr    (bus.req_paddr),
        .sel      (dec_sel),
        .unmapped (dec_unmapped),
        .offset   (dec_offset)
    );

    assign req_any = bus.req_le | bus.req_we;
    assign ack_hit = |(bus.tgt_ack & sel_q);

    always_comb begin
        ack_rdata = '0;
        if (sel_q[TGT_CLINT])
            ack_rdata = bus.tgt_rdata_clint;
        else if (sel_q[TGT_PLIC])
            ack_rdata = bus.tgt_rdata_plic;
        else if (sel_q[TGT_UART])
            ack_rdata = bus.tgt_rdata_uart;
    end

    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        is_wr_nxt = is_wr;
        busy_nxt  = busy_q;
        rdata_nxt = rdata_q;
        err_nxt   = 1'b0;
        sel_nxt   = sel_q;
        addr_nxt  = addr_q;
        re_nxt    = 1'b0;
        we_nxt    = 1'b0;
        wdata_nxt = wdata_q;
        tmo_nxt   = tmo_cnt;

        // A request must be seen low before it can be accepted again.
        if (!req_any)
            armed_nxt = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (req_any && armed) begin
                    armed_nxt = 1'b0;
                    is_wr_nxt = bus.req_we;
                    wdata_nxt = bus.req_wdata;
                    tmo_nxt   = TMO_LOAD;
                    if (dec_unmapped) begin
                        busy_nxt           = '0;
                        busy_nxt[BUSY_ERR] = 1'b1;
                        err_nxt            = 1'b1;
                        if (!bus.req_we)
                            rdata_nxt = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        busy_nxt  = {1'b0, dec_sel};
                        sel_nxt   = dec_sel;
                        addr_nxt  = dec_offset;
                        re_nxt    = !bus.req_we;
                        we_nxt    = bus.req_we;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (ack_hit) begin
                    if (!is_wr)
                        rdata_nxt = ack_rdata;
                    busy_nxt  = '0;
                    sel_nxt   = '0;
                    state_nxt = ST_DONE;
                end else if (state == ST_ISSUE) begin
                    state_nxt = ST_WAIT;
                end else if (tmo_cnt == 8'd1) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    tmo_nxt = tmo_cnt - 8'd1;
                end
            end
            ST_DONE: begin
                busy_nxt  = '0;
                sel_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_X) begin
        if (RST_X) begin
            state   <= ST_IDLE;
            armed   <= 1'b1;
            is_wr   <= 1'b0;
            busy_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            armed   <= armed_nxt;
            is_wr   <= is_wr_nxt;
            busy_q  <= busy_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            sel_q   <= sel_nxt;
            addr_q  <= addr_nxt;
            re_q    <= re_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.tgt_sel   = sel_q;
    assign bus.tgt_addr  = addr_q;
    assign bus.tgt_re    = re_q;
    assign bus.tgt_we    = we_q;
    assign bus.tgt_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: outputs sampled and inputs driven at the
// falling edge, so each loop iteration is one clock cycle after acceptance.
module tb_mmio_router;

    logic CLK = 1'b0;
    logic RST_X = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    mmio_router_if bus();

    mmio_router #(.TIMEOUT_CYCLES(4)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.req_paddr       = '0;
        bus.req_le          = 1'b0;
        bus.req_we          = 1'b0;
        bus.req_wdata       = '0;
        bus.tgt_ack         = '0;
        bus.tgt_rdata_clint = '0;
        bus.tgt_rdata_plic  = '0;
        bus.tgt_rdata_uart  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_X = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL rst_busy got=%b want=0000", bus.busy); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rdata); end
        total++; if ({bus.err, bus.tgt_sel, bus.tgt_re, bus.tgt_we} !== 6'b0) begin bad++;
            $display("FAIL rst_ctl got=%b want=000000", {bus.err, bus.tgt_sel, bus.tgt_re, bus.tgt_we}); end
        total++; if ({bus.tgt_addr, bus.tgt_wdata} !== 64'h0) begin bad++;
            $display("FAIL rst_addr_wdata got=%h/%h want=0/0", bus.tgt_addr, bus.tgt_wdata); end
        RST_X = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL post_rst_busy got=%b want=0000", bus.busy); end
    endtask

    task automatic test_clint_read();
        int n_busy = 0, n_re = 0, n_we = 0, n_err = 0;
        logic [31:0] addr_seen = '0;
        logic [2:0]  sel_seen = '0;
        bus.req_paddr = 32'h0200_BFF8;
        bus.req_le = 1'b1;
        bus.tgt_rdata_clint = 32'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (bus.busy == 4'b0001) n_busy++;
            if (bus.tgt_re) n_re++;
            if (bus.tgt_we) n_we++;
            if (bus.err) n_err++;
            if (c == 1) begin addr_seen = bus.tgt_addr; sel_seen = bus.tgt_sel; bus.req_le = 1'b0; end
            bus.tgt_ack = (c == 4) ? 3'b001 : 3'b000;
        end
        total++; if (n_busy !== 4) begin bad++; $display("FAIL clint_busy_cycles got=%0d want=4", n_busy); end
        total++; if (n_re !== 1 || n_we !== 0) begin bad++; $display("FAIL clint_strobes got re=%0d we=%0d want re=1 we=0", n_re, n_we); end
        total++; if (addr_seen !== 32'h0000_BFF8) begin bad++; $display("FAIL clint_addr got=%h want=0000bff8", addr_seen); end
        total++; if (sel_seen !== 3'b001) begin bad++; $display("FAIL clint_sel got=%b want=001", sel_seen); end
        total++; if (bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL clint_rdata got=%h want=12345678", bus.rdata); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL clint_err got=%0d want=0", n_err); end
    endtask

    task automatic test_uart_write();
        int n_busy = 0, n_re = 0, n_we = 0, n_err = 0;
        logic [31:0] wdata_seen = '0, addr_seen = '1;
        bus.req_paddr = 32'h1000_0000;
        bus.req_we = 1'b1;
        bus.req_wdata = 32'h0000_0041;
        bus.tgt_rdata_uart = 32'hDEAD_BEEF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            if (bus.busy == 4'b0100) n_busy++;
            if (bus.tgt_re) n_re++;
            if (bus.tgt_we) n_we++;
            if (bus.err) n_err++;
            if (c == 1) begin wdata_seen = bus.tgt_wdata; addr_seen = bus.tgt_addr; bus.req_we = 1'b0; end
            bus.tgt_ack = (c == 1) ? 3'b100 : 3'b000;
        end
        total++; if (n_busy !== 1) begin bad++; $display("FAIL uart_busy_cycles got=%0d want=1", n_busy); end
        total++; if (n_we !== 1 || n_re !== 0) begin bad++; $display("FAIL uart_strobes got we=%0d re=%0d want we=1 re=0", n_we, n_re); end
        total++; if (wdata_seen !== 32'h41) begin bad++; $display("FAIL uart_wdata got=%h want=00000041", wdata_seen); end
        total++; if (addr_seen !== 32'h0) begin bad++; $display("FAIL uart_addr got=%h want=0", addr_seen); end
        total++; if (n_err !== 0) begin bad++; $display("FAIL uart_err got=%0d want=0", n_err); end
        total++; if (bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL uart_rdata_kept got=%h want=12345678", bus.rdata); end
    endtask

    task automatic test_unmapped();
        int n_b3 = 0, n_err = 0, n_strobe = 0;
        logic [3:0] busy_c1 = '0;
        logic       err_c1 = 1'b0;
        bus.req_paddr = 32'h8000_0000;
        bus.req_le = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            if (bus.busy == 4'b1000) n_b3++;
            if (bus.err) n_err++;
            if (bus.tgt_re || bus.tgt_we) n_strobe++;
            if (c == 1) begin busy_c1 = bus.busy; err_c1 = bus.err; bus.req_le = 1'b0; end
        end
        total++; if (busy_c1 !== 4'b1000 || n_b3 !== 1) begin bad++; $display("FAIL unmapped_busy got c1=%b cycles=%0d want 1000 x1", busy_c1, n_b3); end
        total++; if (err_c1 !== 1'b1 || n_err !== 1) begin bad++; $display("FAIL unmapped_err got c1=%b pulses=%0d want 1 x1", err_c1, n_err); end
        total++; if (n_strobe !== 0) begin bad++; $display("FAIL unmapped_strobe got=%0d want=0", n_strobe); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL unmapped_rdata got=%h want=0", bus.rdata); end
    endtask

    task automatic test_held_request();
        int n_re = 0, n_busy = 0;
        bus.req_paddr = 32'h0200_0010;
        bus.req_le = 1'b1;
        bus.tgt_rdata_clint = 32'hA5A5_0001;
        for (int c = 1; c <= 14; c++) begin
            @(negedge CLK);
            if (bus.tgt_re) n_re++;
            if (bus.busy != 4'b0) n_busy++;
            bus.tgt_ack = {2'b00, bus.tgt_re & bus.tgt_sel[0]};
        end
        total++; if (n_re !== 1 || n_busy !== 1) begin bad++; $display("FAIL held_single got re=%0d busy=%0d want 1/1", n_re, n_busy); end
        total++; if (bus.rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL held_rdata1 got=%h want=a5a50001", bus.rdata); end
        bus.req_le = 1'b0;
        @(negedge CLK);
        bus.req_le = 1'b1;
        bus.tgt_rdata_clint = 32'hA5A5_0002;
        n_re = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            if (bus.tgt_re) n_re++;
            bus.tgt_ack = {2'b00, bus.tgt_re & bus.tgt_sel[0]};
        end
        total++; if (n_re !== 1) begin bad++; $display("FAIL rearm_second got re=%0d want=1", n_re); end
        total++; if (bus.rdata !== 32'hA5A5_0002) begin bad++; $display("FAIL rearm_rdata got=%h want=a5a50002", bus.rdata); end
        bus.req_le = 1'b0;
        bus.tgt_ack = '0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int n_busy = 0, n_err = 0, err_cycle = 0;
        bus.req_paddr = 32'h0C00_0004;
        bus.req_le = 1'b1;
        bus.tgt_rdata_clint = 32'hFFFF_FFFF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (bus.busy != 4'b0) n_busy++;
            if (bus.err) begin n_err++; err_cycle = c; end
            if (c == 1) bus.req_le = 1'b0;
            bus.tgt_ack = (c == 3) ? 3'b001 : 3'b000;
        end
        total++; if (n_busy !== 6) begin bad++; $display("FAIL timeout_busy_cycles got=%0d want=6", n_busy); end
        total++; if (n_err !== 1 || err_cycle !== 6) begin bad++; $display("FAIL timeout_err got pulses=%0d at=%0d want 1 at 6", n_err, err_cycle); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%h want=0", bus.rdata); end
    endtask

    task automatic test_reset_mid();
        int n_busy = 0;
        bus.req_paddr = 32'h0C00_0008;
        bus.req_le = 1'b1;
        bus.tgt_rdata_plic = 32'h7777_0000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (c == 1) bus.req_le = 1'b0;
            bus.tgt_ack = {1'b0, bus.tgt_re & bus.tgt_sel[1], 1'b0};
        end
        total++; if (bus.rdata !== 32'h7777_0000) begin bad++; $display("FAIL plic_rdata got=%h want=77770000", bus.rdata); end

        bus.req_paddr = 32'h0C00_0100;
        bus.req_we = 1'b1;
        bus.req_wdata = 32'h0000_0055;
        @(negedge CLK);
        bus.req_we = 1'b0;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        #1;
        total++; if (bus.busy !== 4'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL midrst_busy_err got=%b/%b want 0000/0", bus.busy, bus.err); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h want=0", bus.rdata); end
        total++; if ({bus.tgt_sel, bus.tgt_re, bus.tgt_we} !== 5'b0) begin bad++;
            $display("FAIL midrst_tgt_ctl got=%b want=00000", {bus.tgt_sel, bus.tgt_re, bus.tgt_we}); end
        total++; if (bus.tgt_addr !== 32'h0 || bus.tgt_wdata !== 32'h0) begin bad++;
            $display("FAIL midrst_tgt_data got=%h/%h want=0/0", bus.tgt_addr, bus.tgt_wdata); end
        @(negedge CLK);
        RST_X = 1'b0;
        @(negedge CLK);

        bus.req_paddr = 32'h0200_0000;
        bus.req_le = 1'b1;
        bus.tgt_rdata_clint = 32'h0BAD_F00D;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            if (bus.busy == 4'b0001) n_busy++;
            if (c == 1) bus.req_le = 1'b0;
            bus.tgt_ack = {2'b00, bus.tgt_re & bus.tgt_sel[0]};
        end
        total++; if (n_busy !== 1) begin bad++; $display("FAIL postrst_busy got=%0d want=1", n_busy); end
        total++; if (bus.rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL postrst_rdata got=%h want=0badf00d", bus.rdata); end
    endtask

    initial begin
        test_reset();
        test_clint_read();
        test_uart_write();
        test_unmapped();
        test_held_request();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
